// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the byte-serial wide adder.
// State encoding is fixed so that debug probes and scripts can decode it.
package serial_add_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The "slave" side is the adder; the "master" side supplies operands and takes results.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) ();

  localparam int W = BYTE_W * NBYTES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport master (
    output in_valid, op_a, op_b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

endinterface

// File: rtl/serial_add_ctrl_fadder8.sv
// 8-bit full-adder slice, the shared arithmetic resource of the serial adder.
module serial_add_ctrl_fadder8 (
  output logic [7:0] sum,
  output logic       carry,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in
);

  assign {carry, sum} = 9'(a) + 9'(b) + 9'(c_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide add/subtract engine: one 8-bit slice reused for NBYTES cycles,
// LSB byte first, with the inter-byte carry held in a register.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for operands, in_ready high
//   ST_RUN  | processing byte idx, one byte per clock
//   ST_DONE | result valid, held until out_ready
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus,
  output logic               busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               c_out_q;
  logic               ovf_q;

  logic               in_ready_w;
  logic               accept;
  logic               last_byte;
  logic [BYTE_W-1:0]  a_byte;
  logic [BYTE_W-1:0]  b_byte;
  logic [BYTE_W-1:0]  slice_sum;
  logic               slice_carry;

  assign in_ready_w = (state_q == ST_IDLE);
  assign accept     = bus.in_valid && in_ready_w;
  assign last_byte  = (idx_q == IDX_W'(NBYTES - 1));

  assign a_byte = a_q[BYTE_W*int'(idx_q) +: BYTE_W];
  assign b_byte = b_q[BYTE_W*int'(idx_q) +: BYTE_W];

  serial_add_ctrl_fadder8 u_slice (
    .sum   (slice_sum),
    .carry (slice_carry),
    .a     (a_byte),
    .b     (b_byte),
    .c_in  (carry_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)        state_d = ST_RUN;
      ST_RUN:  if (last_byte)     state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Subtraction is folded into the accept: B is stored inverted and the
  // carry seeded with 1, so RUN never needs to know the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q     <= bus.op_a;
            b_q     <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.sub | bus.c_in;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_q[BYTE_W*int'(idx_q) +: BYTE_W] <= slice_sum;
          carry_q <= slice_carry;
          if (last_byte) begin
            idx_q   <= '0;
            c_out_q <= slice_carry;
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (slice_sum[BYTE_W-1] != a_q[W-1]);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed cases on a 4-byte instance, then a
// random sweep on 4-byte and 2-byte instances against an arithmetic model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_d     = 2'b11;
  logic [1:0]  drv_valid = 2'b00;
  logic [1:0]  drv_ci    = 2'b00;
  logic [1:0]  drv_sub   = 2'b00;
  logic [1:0]  man_ordy  = 2'b00;
  logic [1:0]  rnd_ordy  = 2'b00;
  logic [1:0]  ordy_rand = 2'b00;
  logic [1:0]  drv_ordy;
  logic [31:0] drv_a [2];
  logic [31:0] drv_b [2];

  logic [1:0]  mon_irdy, mon_ov, mon_busy, mon_c, mon_ovf;
  logic [31:0] mon_sum [2];
  logic        busy4, busy2;

  assign drv_ordy = (ordy_rand & rnd_ordy) | (~ordy_rand & man_ordy);

  serial_add_ctrl_if #(.NBYTES(4)) bus4 ();
  serial_add_ctrl_if #(.NBYTES(2)) bus2 ();

  assign bus4.in_valid  = drv_valid[0];
  assign bus4.op_a      = drv_a[0];
  assign bus4.op_b      = drv_b[0];
  assign bus4.c_in      = drv_ci[0];
  assign bus4.sub       = drv_sub[0];
  assign bus4.out_ready = drv_ordy[0];
  assign bus2.in_valid  = drv_valid[1];
  assign bus2.op_a      = drv_a[1][15:0];
  assign bus2.op_b      = drv_b[1][15:0];
  assign bus2.c_in      = drv_ci[1];
  assign bus2.sub       = drv_sub[1];
  assign bus2.out_ready = drv_ordy[1];

  assign mon_irdy = {bus2.in_ready,  bus4.in_ready};
  assign mon_ov   = {bus2.out_valid, bus4.out_valid};
  assign mon_busy = {busy2, busy4};
  assign mon_c    = {bus2.c_out, bus4.c_out};
  assign mon_ovf  = {bus2.ovf,   bus4.ovf};
  assign mon_sum[0] = bus4.sum;
  assign mon_sum[1] = {16'd0, bus2.sum};

  serial_add_ctrl #(.NBYTES(4)) dut4 (.clk(clk), .rst(rst_d[0]), .bus(bus4), .busy(busy4));
  serial_add_ctrl #(.NBYTES(2)) dut2 (.clk(clk), .rst(rst_d[1]), .bus(bus2), .busy(busy2));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          nbv [2] = '{4, 2};
  bit          m_init [2];
  int          m_remain [2];
  bit          m_res_valid [2];
  logic [31:0] m_sum [2];
  logic        m_c [2];
  logic        m_ovf [2];
  int          acc_cnt [2];

  function automatic void model_op(input int nb, input logic [31:0] a_in, input logic [31:0] b_in,
                                   input logic ci, input logic s,
                                   output logic [31:0] rs, output logic rc, output logic rv);
    longint md, a, b, t, sa, sb, v;
    md = longint'(1) << (8 * nb);
    a  = longint'(a_in) % md;
    b  = longint'(b_in) % md;
    sa = (a >= md / 2) ? a - md : a;
    sb = (b >= md / 2) ? b - md : b;
    if (s) begin
      t  = (a - b + md) % md;
      rc = (a >= b);
      v  = sa - sb;
    end else begin
      t  = a + b + longint'(ci);
      rc = (t >= md);
      t  = t % md;
      v  = sa + sb + longint'(ci);
    end
    rs = 32'(t);
    rv = (v < -(md / 2)) || (v >= md / 2);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst_d[i]) begin
          m_init[i] = 1'b1; m_remain[i] = 0; m_res_valid[i] = 1'b0;
          m_sum[i] = '0; m_c[i] = 1'b0; m_ovf[i] = 1'b0;
        end else if (m_init[i]) begin
          if (m_res_valid[i]) begin
            if (drv_ordy[i]) m_res_valid[i] = 1'b0;
          end else if (m_remain[i] > 0) begin
            m_remain[i]--;
            if (m_remain[i] == 0) m_res_valid[i] = 1'b1;
          end else if (drv_valid[i]) begin
            model_op(nbv[i], drv_a[i], drv_b[i], drv_ci[i], drv_sub[i], m_sum[i], m_c[i], m_ovf[i]);
            m_remain[i] = nbv[i];
            acc_cnt[i]++;
          end
        end
      end
    end
  end

  // Result fields are only defined while no operation is in flight.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_init[i]) begin
          chk($sformatf("busy_nb%0d", nbv[i]), mon_busy[i], m_remain[i] > 0);
          chk($sformatf("in_ready_nb%0d", nbv[i]), mon_irdy[i], !m_res_valid[i] && m_remain[i] == 0);
          chk($sformatf("out_valid_nb%0d", nbv[i]), mon_ov[i], m_res_valid[i]);
          if (m_remain[i] == 0) begin
            chk($sformatf("sum_nb%0d", nbv[i]), mon_sum[i], m_sum[i]);
            chk($sformatf("c_out_nb%0d", nbv[i]), mon_c[i], m_c[i]);
            chk($sformatf("ovf_nb%0d", nbv[i]), mon_ovf[i], m_ovf[i]);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ordy = 2'($urandom_range(0, 3));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic s);
    int start;
    bit got;
    drv_a[i] = a; drv_b[i] = b; drv_ci[i] = ci; drv_sub[i] = s;
    drv_valid[i] = 1'b1;
    start = acc_cnt[i];
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk);
      #1;
      got = (acc_cnt[i] != start);
    end
    drv_valid[i] = 1'b0;
    chk($sformatf("accept_seen_nb%0d", nbv[i]), got, 1'b1);
  endtask

  task automatic wait_result(input int i);
    for (int k = 0; k < 50 && !m_res_valid[i]; k++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("result_seen_nb%0d", nbv[i]), m_res_valid[i], 1'b1);
  endtask

  task automatic handoff0();
    man_ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    man_ordy[0] = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic s,
                         input logic [31:0] esum, input logic ec, input logic eovf);
    send(0, a, b, ci, s);
    wait_result(0);
    chk({name, "_valid"}, mon_ov[0], 1'b1);
    chk({name, "_sum"},   mon_sum[0], esum);
    chk({name, "_c_out"}, mon_c[0], ec);
    chk({name, "_ovf"},   mon_ovf[0], eovf);
    handoff0();
  endtask

  function automatic logic [31:0] pick(input int nb);
    logic [31:0] m;
    m = (nb == 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      2:       return (m >> 1) + 32'd1;
      3:       return m >> 1;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic rand_run(input int i, input int nops);
    for (int n = 0; n < nops; n++) begin
      send(i, pick(nbv[i]), pick(nbv[i]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    wait_result(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, bcnt, start;
    drv_a[0] = '0; drv_b[0] = '0; drv_a[1] = '0; drv_b[1] = '0;

    // Reset held for two edges
    repeat (2) @(posedge clk);
    #1;
    rst_d = 2'b00;
    chk("rst_sum",       mon_sum[0], 32'd0);
    chk("rst_c_out",     mon_c[0], 1'b0);
    chk("rst_ovf",       mon_ovf[0], 1'b0);
    chk("rst_out_valid", mon_ov[0], 1'b0);
    chk("rst_busy",      mon_busy[0], 1'b0);
    chk("rst_in_ready",  mon_irdy[0], 1'b1);

    // Latency and busy window
    send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    lat = 0;
    bcnt = 0;
    for (int k = 0; k < 20 && !mon_ov[0]; k++) begin
      if (mon_busy[0]) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lat_cycles",  lat, 4);
    chk("busy_cycles", bcnt, 4);
    chk("add1_sum",    mon_sum[0], 32'h0000_0100);
    chk("add1_c_out",  mon_c[0], 1'b0);
    chk("add1_ovf",    mon_ovf[0], 1'b0);
    handoff0();

    run_lit("ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_lit("posovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_lit("sub5_7",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_lit("subovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure in DONE with in_valid high and operands moving
    send(0, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
    wait_result(0);
    start = acc_cnt[0];
    drv_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drv_a[0] = $urandom;
      drv_b[0] = $urandom;
      chk("bp_sum",      mon_sum[0], 32'h0000_68AC);
      chk("bp_in_ready", mon_irdy[0], 1'b0);
      chk("bp_valid",    mon_ov[0], 1'b1);
      @(posedge clk);
      #1;
    end
    chk("bp_no_accept", acc_cnt[0], start);
    drv_a[0] = 32'h0000_0010;
    drv_b[0] = 32'h0000_0020;
    handoff0();
    chk("bp_handoff_valid",    mon_ov[0], 1'b0);
    chk("bp_handoff_in_ready", mon_irdy[0], 1'b1);
    chk("bp_handoff_busy",     mon_busy[0], 1'b0);
    @(posedge clk);
    #1;
    drv_valid[0] = 1'b0;
    chk("bp_next_busy",   mon_busy[0], 1'b1);
    chk("bp_next_accept", acc_cnt[0], start + 1);
    wait_result(0);
    chk("bp_next_sum", mon_sum[0], 32'h0000_0030);
    handoff0();

    // Reset while processing byte 2
    send(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_d[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_d[0] = 1'b0;
    chk("abort_sum",      mon_sum[0], 32'd0);
    chk("abort_c_out",    mon_c[0], 1'b0);
    chk("abort_ovf",      mon_ovf[0], 1'b0);
    chk("abort_busy",     mon_busy[0], 1'b0);
    chk("abort_in_ready", mon_irdy[0], 1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("abort_no_valid", mon_ov[0], 1'b0);
      @(posedge clk);
      #1;
    end
    run_lit("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Random sweep on both widths
    ordy_rand = 2'b11;
    fork
      rand_run(0, 4000);
      rand_run(1, 6000);
    join
    ordy_rand = 2'b00;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
